program_counter_unit: RTL
=========================

# program_counter_unit

Registered program-counter unit for the mincore fetch stage. It holds the architectural PC and computes the next PC for sequential flow, JAL, JALR, conditional branches, traps and MRET. It detects misaligned targets, saves the exception PC, cause and value, and counts retired instructions. It sits between the decoder/ALU (which supply op, operands and branch outcome) and instruction memory (which consumes `pc`).

## Interface
Parameters:
- ADDR_W, 32: PC and target width; all address arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset.
- TRAP_VEC, 'h100: trap handler address; must be IALIGN-aligned.
- IALIGN, 4: instruction alignment in bytes, 4 or 2; also the sequential increment.
- CAUSE_W, 4: cause field width.
- MISALIGN_CAUSE, 0: cause code written on a misaligned-target trap.
- COUNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- op  in  `PC_OP_W`  from pc.vh: PC_OP_NEXT, PC_OP_JAL, PC_OP_JALR, PC_OP_BRANCH, PC_OP_TRAP, PC_OP_MRET (`PC_OP_W` = 3)
- advance  in  1  current instruction completes this cycle; 0 = stall, hold all state
- branch_taken  in  1  branch outcome, used only with PC_OP_BRANCH
- rs1  in  ADDR_W  JALR base
- imm_i, imm_b, imm_j  in  ADDR_W  sign-extended immediates
- trap_req  in  1  exception raised by the current instruction
- trap_cause  in  CAUSE_W  cause code for trap_req or PC_OP_TRAP
- pc  out  ADDR_W  current fetch address
- pc_valid  out  1  pc is a valid fetch address
- link_pc  out  ADDR_W  pc + IALIGN, combinational
- epc, tval  out  ADDR_W  saved exception PC / trap value
- cause  out  CAUSE_W  saved cause
- trap_taken  out  1  one-cycle pulse after a trap is taken
- instret  out  COUNT_W  retired-instruction count

## Operation
- States: BOOT, RUN. Reset enters BOOT. BOOT lasts exactly one cycle, then the unit moves to RUN unconditionally. In BOOT, pc_valid = 0 and advance is ignored.
- In RUN with advance = 0, all registers hold.
- In RUN with advance = 1, the candidate target is:
  - NEXT: pc + IALIGN
  - JAL: pc + imm_j
  - JALR: (rs1 + imm_i) with bit 0 cleared
  - BRANCH: pc + imm_b if branch_taken, else pc + IALIGN
  - MRET: epc
- Misaligned target: for IALIGN = 4, the target is misaligned when target[1:0] ≠ 0; for IALIGN = 2, when target[0] ≠ 0.
- The misalignment check applies only to JAL, JALR and a taken BRANCH.
- Priority, highest first:
  1. trap_req or PC_OP_TRAP: pc ← TRAP_VEC, epc ← pc, cause ← trap_cause, tval ← 0.
  2. Misaligned target: pc ← TRAP_VEC, epc ← pc, cause ← MISALIGN_CAUSE, tval ← target.
  3. Otherwise: pc ← target.
- Any trap registers trap_taken = 1 for the following cycle.
- instret increments by 1 on every RUN advance that takes no trap (MRET counts as retired). It wraps silently from all-ones to 0.
- A trap taken inside the handler overwrites epc, cause and tval; there is no nesting.

## Timing
- Reset values: pc = RESET_PC, pc_valid = 0, epc = 0, tval = 0, cause = 0, trap_taken = 0, instret = 0, state = BOOT.
- The first cycle after rst deasserts shows pc_valid = 0. pc_valid = 1 from the second cycle onward, with pc = RESET_PC.
- Next-PC latency is 1: the target is visible on pc the cycle after the advancing edge.
- link_pc follows pc combinationally, with zero latency.
- trap_taken is high for exactly one cycle, coincident with pc = TRAP_VEC.
- rst asserted mid-operation (including on a trap cycle) wins: every register takes its reset value at that edge, and no trap_taken pulse follows.
- An MRET in the same cycle as trap_req takes the trap: epc ← current pc, and the old epc is lost.

## Test plan
- Reset with RESET_PC = 'h80 → one cycle pc_valid = 0, then pc = 'h80; 3 NEXT advances → pc = 'h8C, instret = 3.
- Stall and branches: advance = 0 for 4 cycles → pc and instret hold. At pc = 'h10, BRANCH with imm_b = 'h20: taken → pc = 'h30; not taken → pc = 'h14.
- JALR with rs1 = 'h1001, imm_i = 0 → pc = 'h1000, link_pc during the instruction = pc + 4. JAL with imm_j = 'h2 at pc = 'h40 (IALIGN = 4) → pc = TRAP_VEC, epc = 'h40, tval = 'h42, cause = 0, trap_taken pulses once, instret unchanged.
- trap_req with trap_cause = 'hB at pc = 'h200 together with op = JAL → trap wins: epc = 'h200, cause = 'hB, tval = 0. Then MRET → pc = 'h200.
- instret preloaded to all-ones via 2^COUNT_W − 1 advances (COUNT_W = 4) → next advance gives instret = 0.
- rst asserted on the same cycle as trap_req → all outputs take reset values and trap_taken stays 0.

Source files
------------

// File: rtl/program_counter_unit_if.sv
// Bundle between the decoder/ALU and the program-counter unit.
// The decoder side drives the control/operand fields; the PC unit drives the fetch/trap state back.
interface program_counter_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int CAUSE_W = 4,
  parameter int COUNT_W = 32
) ();
  logic [2:0]         op;
  logic               advance;
  logic               branch_taken;
  logic [ADDR_W-1:0]  rs1;
  logic [ADDR_W-1:0]  imm_i;
  logic [ADDR_W-1:0]  imm_b;
  logic [ADDR_W-1:0]  imm_j;
  logic               trap_req;
  logic [CAUSE_W-1:0] trap_cause;

  logic [ADDR_W-1:0]  pc;
  logic               pc_valid;
  logic [ADDR_W-1:0]  link_pc;
  logic [ADDR_W-1:0]  epc;
  logic [ADDR_W-1:0]  tval;
  logic [CAUSE_W-1:0] cause;
  logic               trap_taken;
  logic [COUNT_W-1:0] instret;

  modport master (
    output op, advance, branch_taken, rs1, imm_i, imm_b, imm_j, trap_req, trap_cause,
    input  pc, pc_valid, link_pc, epc, tval, cause, trap_taken, instret
  );

  modport slave (
    input  op, advance, branch_taken, rs1, imm_i, imm_b, imm_j, trap_req, trap_cause,
    output pc, pc_valid, link_pc, epc, tval, cause, trap_taken, instret
  );
endinterface

// File: rtl/program_counter_unit.sv
// Architectural PC for the mincore fetch stage: next-PC selection, trap entry,
// misaligned-target detection, exception state and retired-instruction count.
module program_counter_unit #(
  parameter int                  ADDR_W         = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC       = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0]   TRAP_VEC       = ADDR_W'(32'h0000_0100),
  parameter int                  IALIGN         = 4,
  parameter int                  CAUSE_W        = 4,
  parameter logic [CAUSE_W-1:0]  MISALIGN_CAUSE = {CAUSE_W{1'b0}},
  parameter int                  COUNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  program_counter_unit_if.slave  bus
);

  localparam logic [2:0] PC_OP_NEXT   = 3'd0;
  localparam logic [2:0] PC_OP_JAL    = 3'd1;
  localparam logic [2:0] PC_OP_JALR   = 3'd2;
  localparam logic [2:0] PC_OP_BRANCH = 3'd3;
  localparam logic [2:0] PC_OP_TRAP   = 3'd4;
  localparam logic [2:0] PC_OP_MRET   = 3'd5;

  localparam logic [ADDR_W-1:0]  INC       = ADDR_W'(IALIGN);
  localparam logic [ADDR_W-1:0]  ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  BIT0_CLR  = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [CAUSE_W-1:0] ZERO_CSE  = {CAUSE_W{1'b0}};
  localparam logic [COUNT_W-1:0] ZERO_CNT  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] ONE_CNT   = {{(COUNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [ADDR_W-1:0]    pc_r, pc_s;
  logic                 valid_r, valid_s;
  logic [ADDR_W-1:0]    epc_r, epc_s;
  logic [ADDR_W-1:0]    tval_r, tval_s;
  logic [CAUSE_W-1:0]   cause_r, cause_s;
  logic                 trap_r, trap_s;
  logic [COUNT_W-1:0]   instret_r, instret_s;
  logic [ADDR_W-1:0]    target_s;
  logic                 check_s;
  logic                 misaligned_s;

  // Halfword targets are legal when compressed instructions are enabled.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] t);
    return (IALIGN == 2) ? t[0] : (t[1:0] != 2'b00);
  endfunction

  // State and architectural registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= BOOT;
      pc_r      <= RESET_PC;
      valid_r   <= 1'b0;
      epc_r     <= ZERO_ADDR;
      tval_r    <= ZERO_ADDR;
      cause_r   <= ZERO_CSE;
      trap_r    <= 1'b0;
      instret_r <= ZERO_CNT;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      valid_r   <= valid_s;
      epc_r     <= epc_s;
      tval_r    <= tval_s;
      cause_r   <= cause_s;
      trap_r    <= trap_s;
      instret_r <= instret_s;
    end
  end

  // Candidate target, misalignment check, and next-state selection.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    valid_s   = valid_r;
    epc_s     = epc_r;
    tval_s    = tval_r;
    cause_s   = cause_r;
    trap_s    = 1'b0;
    instret_s = instret_r;
    target_s  = pc_r + INC;

    case (bus.op)
      PC_OP_NEXT:   target_s = pc_r + INC;
      PC_OP_JAL:    target_s = pc_r + bus.imm_j;
      PC_OP_JALR:   target_s = (bus.rs1 + bus.imm_i) & BIT0_CLR;
      PC_OP_BRANCH: target_s = bus.branch_taken ? (pc_r + bus.imm_b) : (pc_r + INC);
      PC_OP_MRET:   target_s = epc_r;
      default:      target_s = pc_r + INC;
    endcase

    // MRET returns to whatever epc holds, so it is not alignment-checked.
    check_s      = (bus.op == PC_OP_JAL) || (bus.op == PC_OP_JALR) ||
                   ((bus.op == PC_OP_BRANCH) && bus.branch_taken);
    misaligned_s = check_s && is_misaligned(target_s);

    case (state_r)
      BOOT: begin
        state_s = RUN;
        valid_s = 1'b1;
      end
      RUN: begin
        if (bus.advance) begin
          if (bus.trap_req || (bus.op == PC_OP_TRAP)) begin
            pc_s    = TRAP_VEC;
            epc_s   = pc_r;
            cause_s = bus.trap_cause;
            tval_s  = ZERO_ADDR;
            trap_s  = 1'b1;
          end else if (misaligned_s) begin
            pc_s    = TRAP_VEC;
            epc_s   = pc_r;
            cause_s = MISALIGN_CAUSE;
            tval_s  = target_s;
            trap_s  = 1'b1;
          end else begin
            pc_s      = target_s;
            instret_s = instret_r + ONE_CNT;
          end
        end else begin
          trap_s = 1'b0;
        end
      end
      default: begin
        state_s = BOOT;
        valid_s = 1'b0;
      end
    endcase
  end

  assign bus.pc         = pc_r;
  assign bus.pc_valid   = valid_r;
  assign bus.link_pc    = pc_r + INC;
  assign bus.epc        = epc_r;
  assign bus.tval       = tval_r;
  assign bus.cause      = cause_r;
  assign bus.trap_taken = trap_r;
  assign bus.instret    = instret_r;

endmodule
